// File: rtl/arbiter_8_to_1.sv
// arbiter_8_to_1: eight-source round-robin merge into a single registered
// output slot with valid/ready handshake towards the sink.
// Each capture pulses a one-hot ack back to the winning source for one cycle.
// Optional macro ARB_ENABLE_PORT_EN adds an "enable" input that gates capture
// without affecting draining of the output slot.
module arbiter_8_to_1 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     req,
  input  logic [8*W-1:0] din,
  input  logic           y_ready,
`ifdef ARB_ENABLE_PORT_EN
  input  logic           enable,
`endif
  output logic [7:0]     ack,
  output logic [W-1:0]   y,
  output logic           y_valid,
  output logic [2:0]     sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_y;
  logic [2:0]     r_sel;
  logic [2:0]     r_last;
  logic [7:0]     r_ack;

  logic           w_enable;
  logic           w_slot_free;
  logic           w_capture;
  logic [7:0]     w_req_rot;
  logic [2:0]     w_offset;
  logic [2:0]     w_winner;

`ifdef ARB_ENABLE_PORT_EN
  assign w_enable = enable;
`else
  assign w_enable = 1'b1;
`endif

  // The slot can take a new word when empty, or when the current word leaves
  // on this same edge.
  assign w_slot_free = (r_state == EMPTY) || y_ready;
  assign w_capture   = (|req) && w_slot_free && w_enable;

  // Rotate the request vector so bit 0 is the source right after the last
  // winner; the lowest set bit of the rotated vector is then the next grant.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign w_req_rot[gi] = req[3'(r_last + 3'(gi + 1))];
    end
  endgenerate

  // Priority scan of the rotated requests: lowest set bit wins.
  always_comb begin
    w_offset = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_offset = 3'(i);
      end
    end
  end

  assign w_winner = 3'(r_last + 3'd1 + w_offset);

  // State register: EMPTY/FULL mirrors y_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a capture always fills the slot; otherwise a full slot
  // empties only when the sink takes the word.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY: begin
        if (w_capture) begin
          w_state_next = FULL;
        end
      end
      FULL: begin
        if (w_capture) begin
          w_state_next = FULL;
        end else if (y_ready) begin
          w_state_next = EMPTY;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // Output datapath: load the winner's word on capture; otherwise hold,
  // including y after it is drained. ack is a single-cycle one-hot pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y    <= '0;
      r_sel  <= 3'd0;
      r_last <= 3'd7;
      r_ack  <= 8'h00;
    end else begin
      r_ack <= 8'h00;
      if (w_capture) begin
        r_y    <= din[w_winner*W +: W];
        r_sel  <= w_winner;
        r_last <= w_winner;
        r_ack  <= 8'h01 << w_winner;
      end
    end
  end

  assign ack     = r_ack;
  assign y       = r_y;
  assign sel     = r_sel;
  assign y_valid = (r_state == FULL);

endmodule

// File: tb/tb_arbiter_8_to_1.sv
// Directed testbench for arbiter_8_to_1 with hand-computed expectations.
// Exercises the enable gate too when ARB_ENABLE_PORT_EN is defined.
module tb_arbiter_8_to_1;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [7:0]     req;
  logic [8*W-1:0] din;
  logic           y_ready;
`ifdef ARB_ENABLE_PORT_EN
  logic           enable;
`endif
  logic [7:0]     ack;
  logic [W-1:0]   y;
  logic           y_valid;
  logic [2:0]     sel;

  int n_checks = 0;
  int n_pass   = 0;

  arbiter_8_to_1 #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .din     (din),
    .y_ready (y_ready),
`ifdef ARB_ENABLE_PORT_EN
    .enable  (enable),
`endif
    .ack     (ack),
    .y       (y),
    .y_valid (y_valid),
    .sel     (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("check %s: got %0h", tag, obs);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 8'h00;
    din     = '0;
    y_ready = 1'b0;
`ifdef ARB_ENABLE_PORT_EN
    enable  = 1'b1;
`endif
    @(negedge clk);

    // Reset state
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_ack",     32'(ack),     32'h00);
    check("rst_y",       32'(y),       32'h00);
    check("rst_sel",     32'(sel),     32'd0);

    // Single request from source 0
    rst_n = 1'b1;
    req = 8'h01;
    din[0 +: 8] = 8'hA5;
    y_ready = 1'b1;
    tick();
    check("single_ack",     32'(ack),     32'h01);
    check("single_y",       32'(y),       32'hA5);
    check("single_sel",     32'(sel),     32'd0);
    check("single_y_valid", 32'(y_valid), 32'd1);

    // Requests drop: slot drains, y keeps its value
    req = 8'h00;
    tick();
    check("drain_y_valid", 32'(y_valid), 32'd0);
    check("drain_ack",     32'(ack),     32'h00);
    check("drain_y_hold",  32'(y),       32'hA5);

    // Fresh reset, then all sources request: 0..7 then wrap to 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'(8'h10 + i);
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("rr_sel%0d", i),   32'(sel),     32'(i % 8));
      check($sformatf("rr_ack%0d", i),   32'(ack),     32'(8'h01 << (i % 8)));
      check($sformatf("rr_y%0d", i),     32'(y),       32'(8'h10 + (i % 8)));
      check($sformatf("rr_valid%0d", i), 32'(y_valid), 32'd1);
    end

    // last = 0: only source 4 -> grant 4
    req = 8'h10;
    tick();
    check("set_last4_sel", 32'(sel), 32'd4);
    // last = 4, sources 4 and 7: 7 first, then 4
    req = 8'h90;
    tick();
    check("p90_first_sel", 32'(sel), 32'd7);
    check("p90_first_ack", 32'(ack), 32'h80);
    tick();
    check("p90_second_sel", 32'(sel), 32'd4);
    check("p90_second_ack", 32'(ack), 32'h10);

    // Stall: y holds slice 4 (8'h14); source 1 waits
    y_ready = 1'b0;
    req = 8'h02;
    din[8 +: 8] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_y%0d", i),     32'(y),       32'h14);
      check($sformatf("stall_sel%0d", i),   32'(sel),     32'd4);
      check($sformatf("stall_ack%0d", i),   32'(ack),     32'h00);
      check($sformatf("stall_valid%0d", i), 32'(y_valid), 32'd1);
    end
    y_ready = 1'b1;
    tick();
    check("unstall_sel",   32'(sel),     32'd1);
    check("unstall_ack",   32'(ack),     32'h02);
    check("unstall_y",     32'(y),       32'h5A);
    check("unstall_valid", 32'(y_valid), 32'd1);

    // Mid-stream asynchronous reset between edges
    req = 8'hFF;
    tick();
    check("pre_rst_sel",   32'(sel),     32'd2);
    check("pre_rst_valid", 32'(y_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(y_valid), 32'd0);
    check("async_rst_ack",   32'(ack),     32'h00);
    check("async_rst_y",     32'(y),       32'h00);
    #2 rst_n = 1'b1;
    req = 8'h0C;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_sel",   32'(sel),     32'd2);
    check("post_rst_ack",   32'(ack),     32'h04);
    check("post_rst_y",     32'(y),       32'h12);
    check("post_rst_valid", 32'(y_valid), 32'd1);

    req = 8'h00;
    tick();
    check("idle_valid", 32'(y_valid), 32'd0);
    check("idle_ack",   32'(ack),     32'h00);

`ifdef ARB_ENABLE_PORT_EN
    // Enable gate: no capture while low, capture on first edge once high
    enable = 1'b0;
    req = 8'h08;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("en_off_ack%0d", i),   32'(ack),     32'h00);
      check($sformatf("en_off_valid%0d", i), 32'(y_valid), 32'd0);
    end
    enable = 1'b1;
    tick();
    check("en_on_ack", 32'(ack), 32'h08);
    check("en_on_sel", 32'(sel), 32'd3);
    req = 8'h00;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arbiter_8_to_1.md
ARBITER_8_TO_1 -- requirements
Module: arbiter_8_to_1

Interface
REQ-001 Parameter: W, default 8, data width of every source slice and of the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  per-source request; bit i high = source i has data on its din slice.
REQ-005 din  input  8*W  source data, flattened; source i occupies bits [i*W +: W].
REQ-006 ack  output  8  one-hot, one-cycle pulse; bit i = source i's data was captured this edge.
REQ-007 y  output  W  merged output data (registered).
REQ-008 y_valid  output  1  y holds an unconsumed word.
REQ-009 y_ready  input  1  sink accepts y; transfer when y_valid && y_ready on a rising edge.
REQ-010 sel  output  3  index of the source whose word is in y (registered alongside y).

Function
REQ-011 States: EMPTY (y_valid=0) and FULL (y_valid=1); no other states.
REQ-012 Capture condition: (|req) && (!y_valid || y_ready); the output slot is free or is being drained on the same edge.
REQ-013 On capture: winner k loaded into y <= din[k*W +: W], sel <= k, y_valid <= 1, ack <= one-hot(k) for exactly one cycle, last <= k.
REQ-014 Winner k: first requesting index scanning last+1, last+2, ... modulo 8; wraps 7 -> 0.
REQ-015 Source whose request is granted never wins again while any other source requests (strict round robin, no starvation).
REQ-016 Latency: req asserted before edge n -> y_valid and ack visible after edge n (one cycle).
REQ-017 Throughput: with y_ready held high and requests pending, one word per cycle, y_valid held high continuously.
REQ-018 EMPTY -> FULL on capture; FULL -> EMPTY when y_ready && no capture; FULL -> FULL on stall (y_ready=0) or drain-plus-capture.
REQ-019 Stall: while y_valid && !y_ready, y, sel, y_valid, last frozen; ack all zero; req ignored.
REQ-020 Sources hold req and din stable until their ack bit pulses; req still high in cycle after ack counts as a new request.
REQ-021 ack is zero in every cycle without a capture; never more than one bit set.
REQ-022 No capture when req == 0; y retains last value (not cleared) when y_valid drops.

Reset
REQ-023 rst_n low asynchronously forces: y_valid=0, y=0, sel=0, ack=0, last=3'd7 (first priority source 0).
REQ-024 Reset mid-transfer discards the word in y; no ack issued while rst_n low.
REQ-025 First capture permitted on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro ARB_ENABLE_PORT_EN: when defined, adds input port enable (1 bit, after y_ready); enable=0 blocks capture (no ack, last frozen), while draining via y_ready continues normally.
REQ-027 Without ARB_ENABLE_PORT_EN, no enable port exists; behaviour identical to enable tied to 1.

Verification
REQ-028 Reset, then req=8'h01, din slice0=8'hA5, y_ready=1 -> next cycle ack=8'h01, y=8'hA5, sel=0, y_valid=1.
REQ-029 req=8'hFF held (re-asserted after each ack), y_ready=1 -> sel sequence 0,1,...,7,0; one ack per cycle; wrap after 7.
REQ-030 req=8'h90 (sources 4,7), last=4 -> sel=7 granted first, then 4.
REQ-031 y_valid=1, y_ready=0 for 5 cycles, req=8'h02 -> y, sel stable, ack=0; first y_ready=1 edge -> source 1 captured same edge, y_valid stays 1.
REQ-032 rst_n low for 3 ns mid-stream (between edges) -> y_valid=0, ack=0 immediately; after release next grant goes to lowest requesting index.
REQ-033 With ARB_ENABLE_PORT_EN: enable=0, req=8'h08 -> no ack for 4 cycles; enable=1 -> ack=8'h08 next edge.
